// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold values 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_hs.sv
// Full adder built from two half adders and an OR on the carries.
module full_adder_hs (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_adder_dataflow u_ha1 (
        .a     (x),
        .b     (y),
        .sum   (w_s1),
        .c_out (w_c1)
    );

    half_adder_dataflow u_ha2 (
        .a     (w_s1),
        .b     (c_in),
        .sum   (sum),
        .c_out (w_c2)
    );

    assign c_out = w_c1 | w_c2;

endmodule

// File: rtl/half_adder_dataflow.sv
// Combinational half adder in dataflow form.
module half_adder_dataflow (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b;
    assign c_out = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: parallel load, LSB-first add over WIDTH cycles,
// registered result with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_c_out;
    logic [CW-1:0]    r_cnt;

    logic             w_bit;
    logic             w_carry_next;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    full_adder_hs u_fa (
        .x     (r_a_sr[0]),
        .y     (r_b_sr[0]),
        .c_in  (r_carry),
        .sum   (w_bit),
        .c_out (w_carry_next)
    );

    // New bit enters at the MSB; the cast form also covers WIDTH == 1.
    assign w_acc_next = WIDTH'({w_bit, r_acc} >> 1);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end
                end
                SHIFT: begin
                    r_carry <= w_carry_next;
                    r_acc   <= w_acc_next;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum   <= w_acc_next;
                        r_c_out <= w_carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state == SHIFT);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 13 and 1 against an arithmetic timing model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start;
    logic [12:0] a_in [3];
    logic [12:0] b_in [3];
    logic [2:0]  cin;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  cout;
    logic [7:0]  sum8;
    logic [12:0] sum13;
    logic        sum1;
    logic [12:0] sum_o [3];

    int          n_tests = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    int          m_phase [3];
    logic [63:0] m_pend [3];
    logic [12:0] m_sum [3];
    logic        m_cout [3];
    int          m_acc [3];
    int          n_done [3];
    logic [12:0] last_sum [3];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst_n (rst_n), .start (start[0]), .a (a_in[0][7:0]), .b (b_in[0][7:0]),
        .c_in (cin[0]), .busy (busy[0]), .done (done[0]), .sum (sum8), .c_out (cout[0])
    );

    serial_adder #(.WIDTH(13)) u_dut13 (
        .clk (clk), .rst_n (rst_n), .start (start[1]), .a (a_in[1]), .b (b_in[1]),
        .c_in (cin[1]), .busy (busy[1]), .done (done[1]), .sum (sum13), .c_out (cout[1])
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .start (start[2]), .a (a_in[2][0:0]), .b (b_in[2][0:0]),
        .c_in (cin[2]), .busy (busy[2]), .done (done[2]), .sum (sum1), .c_out (cout[2])
    );

    always_comb begin
        sum_o[0] = {5'd0, sum8};
        sum_o[1] = sum13;
        sum_o[2] = {12'd0, sum1};
    end

    function automatic int wof(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 13 : 1);
    endfunction

    function automatic logic [63:0] msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: an accepted op is busy for W cycles, done in the next one, then idle again.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_phase[i] <= 0;
                m_sum[i]   <= '0;
                m_cout[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_phase[i] == 0) begin
                    if (start[i]) begin
                        m_phase[i] <= 1;
                        m_pend[i]  <= ({51'd0, a_in[i]} & msk(wof(i)))
                                    + ({51'd0, b_in[i]} & msk(wof(i))) + 64'(cin[i]);
                        m_acc[i]   <= m_acc[i] + 1;
                    end
                end else if (m_phase[i] <= wof(i)) begin
                    m_phase[i] <= m_phase[i] + 1;
                    if (m_phase[i] == wof(i)) begin
                        m_sum[i]  <= 13'(m_pend[i] & msk(wof(i)));
                        m_cout[i] <= m_pend[i][wof(i)];
                    end
                end else begin
                    m_phase[i] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("busy[w%0d]", wof(i)), 64'(busy[i]),
                      64'(m_phase[i] >= 1 && m_phase[i] <= wof(i)));
                check($sformatf("done[w%0d]", wof(i)), 64'(done[i]),
                      64'(m_phase[i] == wof(i) + 1));
                check($sformatf("sum[w%0d]", wof(i)), 64'(sum_o[i]), 64'(m_sum[i]));
                check($sformatf("c_out[w%0d]", wof(i)), 64'(cout[i]), 64'(m_cout[i]));
                if (done[i]) n_done[i]++;
            end
        end
    end

    task automatic run_op(input int idx, input logic [12:0] av, input logic [12:0] bv,
                          input logic cv, input int hold, input logic [12:0] es,
                          input logic ec);
        int k;
        bit seen;
        @(posedge clk);
        #1;
        a_in[idx]  = av;
        b_in[idx]  = bv;
        cin[idx]   = cv;
        start[idx] = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        start[idx] = 1'b0;
        // Post-capture changes must not affect the result.
        a_in[idx] = 13'($urandom);
        b_in[idx] = 13'($urandom);
        cin[idx]  = 1'($urandom);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 64) begin
            @(negedge clk);
            if (k == 0) check($sformatf("hold sum w%0d", wof(idx)), 64'(sum_o[idx]),
                              64'(last_sum[idx]));
            if (done[idx]) seen = 1'b1;
            else k++;
        end
        if (!seen) begin
            check($sformatf("done timeout w%0d", wof(idx)), 64'(0), 64'(1));
        end else begin
            check($sformatf("latency w%0d", wof(idx)), 64'(k), 64'(wof(idx) - hold + 1));
            check($sformatf("op sum w%0d", wof(idx)), 64'(sum_o[idx]), 64'(es));
            check($sformatf("op c_out w%0d", wof(idx)), 64'(cout[idx]), 64'(ec));
        end
        last_sum[idx] = es;
    endtask

    task automatic rand_run(input int idx);
        int          d0;
        int          a0;
        logic [12:0] av;
        logic [12:0] bv;
        logic        cv;
        logic [63:0] tot;
        d0 = n_done[idx];
        a0 = m_acc[idx];
        for (int n = 0; n < 1000; n++) begin
            av  = 13'($urandom);
            bv  = 13'($urandom);
            cv  = 1'($urandom);
            tot = ({51'd0, av} & msk(wof(idx))) + ({51'd0, bv} & msk(wof(idx))) + 64'(cv);
            run_op(idx, av, bv, cv, int'($urandom_range(1, 3)),
                   13'(tot & msk(wof(idx))), tot[wof(idx)]);
        end
        repeat (2) @(negedge clk);
        check($sformatf("accepts w%0d", wof(idx)), 64'(m_acc[idx] - a0), 64'(1000));
        check($sformatf("done count w%0d", wof(idx)), 64'(n_done[idx] - d0),
              64'(m_acc[idx] - a0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        int first_e;
        for (int i = 0; i < 3; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
            m_acc[i] = 0;
            n_done[i] = 0;
            last_sum[i] = '0;
        end
        start = '0;
        cin   = '0;
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset busy w%0d", wof(i)), 64'(busy[i]), 64'(0));
            check($sformatf("reset done w%0d", wof(i)), 64'(done[i]), 64'(0));
            check($sformatf("reset sum w%0d", wof(i)), 64'(sum_o[i]), 64'(0));
            check($sformatf("reset c_out w%0d", wof(i)), 64'(cout[i]), 64'(0));
        end
        #20 rst_n = 1'b1;
        chk_en = 1'b1;

        run_op(0, 13'h0F, 13'h01, 1'b0, 1, 13'h10, 1'b0);
        run_op(0, 13'hFF, 13'h01, 1'b0, 1, 13'h00, 1'b1);
        run_op(0, 13'h00, 13'h00, 1'b1, 1, 13'h01, 1'b0);

        // start held high; a changes after capture; one done per WIDTH+2 cycles.
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        a_in[0] = 13'h55;
        b_in[0] = 13'hAA;
        cin[0] = 1'b1;
        nd = 0;
        first_e = -1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) a_in[0] = 13'hFF;
            if (e == 10) start[0] = 1'b0;
            @(negedge clk);
            if (done[0]) begin
                nd++;
                if (nd == 1) begin
                    first_e = e;
                    check("cont sum1", 64'(sum8), 64'h00);
                    check("cont c_out1", 64'(cout[0]), 64'(1));
                end else begin
                    check("cont sum2", 64'(sum8), 64'hAA);
                    check("cont c_out2", 64'(cout[0]), 64'(1));
                end
            end
        end
        check("cont done count", 64'(nd), 64'(2));
        check("cont first done edge", 64'(first_e), 64'(8));
        last_sum[0] = 13'hAA;

        // Asynchronous reset in the middle of an operation.
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        a_in[0] = 13'h11;
        b_in[0] = 13'h22;
        cin[0] = 1'b0;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre-abort busy", 64'(busy[0]), 64'(1));
        check("pre-abort sum", 64'(sum8), 64'hAA);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy[0]), 64'(0));
        check("abort done", 64'(done[0]), 64'(0));
        check("abort sum", 64'(sum8), 64'(0));
        check("abort c_out", 64'(cout[0]), 64'(1'b0));
        for (int i = 0; i < 3; i++) last_sum[i] = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_op(0, 13'h03, 13'h04, 1'b0, 1, 13'h07, 1'b0);

        // WIDTH=1: full-adder truth table.
        for (int v = 0; v < 8; v++) begin
            int pc;
            pc = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
            run_op(2, 13'(v & 1), 13'((v >> 1) & 1), 1'((v >> 2) & 1), 1,
                   13'(pc & 1), 1'(pc >> 1));
        end

        fork
            rand_run(0);
            rand_run(1);
        join

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
